// File: rtl/ir_nec_pkg.sv
// ir_nec_pkg: shared state encoding and pulse-width windows for the
// NEC IR receiver. Widths are in 50 us ticks; windows are inclusive.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_LOW,
    S_LEAD_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_REP_STOP
  } state_e;

  localparam logic [7:0] LEAD_LOW_MIN  = 8'd160;
  localparam logic [7:0] LEAD_LOW_MAX  = 8'd200;
  localparam logic [7:0] LEAD_HIGH_MIN = 8'd80;
  localparam logic [7:0] LEAD_HIGH_MAX = 8'd100;
  localparam logic [7:0] REP_HIGH_MIN  = 8'd36;
  localparam logic [7:0] REP_HIGH_MAX  = 8'd54;
  localparam logic [7:0] SHORT_MIN     = 8'd7;
  localparam logic [7:0] SHORT_MAX     = 8'd15;
  localparam logic [7:0] LONG_MIN      = 8'd28;
  localparam logic [7:0] LONG_MAX      = 8'd40;
  localparam logic [7:0] TIMEOUT_W     = 8'd255;

  localparam int FRAME_BITS = 32;

  function automatic logic in_win(
    input logic [7:0] w,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_width_timer.sv
// ir_width_timer: IRDA_RXD synchronizer, edge detect and 50 us width count.
// Ports: clk, rst (sync, high), rxd in; fall, rise, width[7:0], timeout out.
module ir_width_timer
  import ir_nec_pkg::*;
#(
  parameter int TICK_DIV = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       fall,
  output logic       rise,
  output logic [7:0] width,
  output logic       timeout
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          dly_q, dly_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    wid_q, wid_d;

  assign fall    = dly_q & ~sync2_q;
  assign rise    = ~dly_q & sync2_q;
  assign width   = wid_q;
  assign timeout = (wid_q == TIMEOUT_W);

  always_comb begin
    sync1_d = rxd;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
    pre_d   = pre_q;
    wid_d   = wid_q;
    // an edge restarts the measurement even if a tick lands on it
    if (fall | rise) begin
      pre_d = '0;
      wid_d = '0;
    end else if (pre_q == PRE_MAX) begin
      pre_d = '0;
      if (wid_q != TIMEOUT_W) wid_d = wid_q + 8'd1;
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      dly_q   <= 1'b1;
      pre_q   <= '0;
      wid_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
      pre_q   <= pre_d;
      wid_q   <= wid_d;
    end
  end

endmodule

// File: rtl/ir_nec_frame_ctrl.sv
// ir_nec_frame_ctrl: NEC frame sequencer (leader, 32 bits, repeat, checks).
// Ports: CLOCK_50, rst, IRDA_RXD in; data_O, data_valid_O, repeat_O, err_O, busy_O.
module ir_nec_frame_ctrl
  import ir_nec_pkg::*;
#(
  parameter int TICK_DIV   = 2500,
  parameter bit CHECK_ADDR = 1'b1
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic        IRDA_RXD,
  output logic [31:0] data_O,
  output logic        data_valid_O,
  output logic        repeat_O,
  output logic        err_O,
  output logic        busy_O
);

  logic       fall, rise, timeout;
  logic [7:0] width;

  ir_width_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk    (CLOCK_50),
    .rst    (rst),
    .rxd    (IRDA_RXD),
    .fall   (fall),
    .rise   (rise),
    .width  (width),
    .timeout(timeout)
  );

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] data_q, data_d;
  logic        hf_q, hf_d;
  logic        dv_q, dv_d;
  logic        rep_q, rep_d;
  logic        err_q, err_d;
  logic        is_short, is_long, frame_ok;
  logic [31:0] shifted;

  assign is_short = in_win(width, SHORT_MIN, SHORT_MAX);
  assign is_long  = in_win(width, LONG_MIN, LONG_MAX);
  // LSB arrives first, so shifting right leaves bit 0 = first bit
  assign shifted  = {is_long, sh_q[31:1]};
  assign frame_ok =
    (!CHECK_ADDR || (shifted[15:8] == ~shifted[7:0])) &&
    (shifted[31:24] == ~shifted[23:16]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    hf_d    = hf_q;
    dv_d    = 1'b0;
    rep_d   = 1'b0;
    err_d   = 1'b0;
    if (state_q != S_IDLE && timeout) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (fall) state_d = S_LEAD_LOW;
        end
        S_LEAD_LOW: begin
          if (rise) begin
            if (in_win(width, LEAD_LOW_MIN, LEAD_LOW_MAX)) begin
              state_d = S_LEAD_HIGH;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_LEAD_HIGH: begin
          if (fall) begin
            if (in_win(width, LEAD_HIGH_MIN, LEAD_HIGH_MAX)) begin
              idx_d   = '0;
              state_d = S_BIT_LOW;
            end else if (in_win(width, REP_HIGH_MIN, REP_HIGH_MAX)) begin
              state_d = S_REP_STOP;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_BIT_LOW: begin
          if (rise) begin
            if (is_short) begin
              state_d = S_BIT_HIGH;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_BIT_HIGH: begin
          if (fall) begin
            if (is_short || is_long) begin
              sh_d = shifted;
              if (idx_q == 6'(FRAME_BITS - 1)) begin
                state_d = S_IDLE;
                if (frame_ok) begin
                  data_d = shifted;
                  dv_d   = 1'b1;
                  hf_d   = 1'b1;
                end else begin
                  err_d = 1'b1;
                end
              end else begin
                idx_d   = idx_q + 6'd1;
                state_d = S_BIT_LOW;
              end
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_REP_STOP: begin
          if (rise) begin
            state_d = S_IDLE;
            if (is_short && hf_q) rep_d = 1'b1;
            else err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      hf_q    <= 1'b0;
      dv_q    <= 1'b0;
      rep_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      hf_q    <= hf_d;
      dv_q    <= dv_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
    end
  end

  assign data_O       = data_q;
  assign data_valid_O = dv_q;
  assign repeat_O     = rep_q;
  assign err_O        = err_q;
  assign busy_O       = (state_q != S_IDLE);

endmodule

// File: doc/ir_nec_frame_ctrl.md
# ir_nec_frame_ctrl

Frame-level controller for the IR receive path on CLOCK_50. It sequences raw IRDA_RXD pulse-width measurements through the NEC protocol: leader, 32 data bits, stop burst, or a repeat frame. It validates the address/command complement bytes and emits a decoded frame or a repeat or error strobe. It sits between the IRDA_RXD pin and the key-handling logic, and is the sole owner of IR frame timing.

## Interface
- TICK_DIV, 2500: CLOCK_50 cycles per width tick (50 us).
- CHECK_ADDR, 1: 1 = require data[15:8] == ~data[7:0]; 0 = extended NEC, skip address check.
- CLOCK_50  input  1  system clock, 50 MHz.
- rst  input  1  reset; synchronous, active-high.
- IRDA_RXD  input  1  raw receiver output, asynchronous; idle high, burst low.
- data_O  output  32  last valid frame, LSB-first byte order: [7:0] address, [15:8] ~address, [23:16] command, [31:24] ~command.
- data_valid_O  output  1  one-cycle strobe when a new frame is latched into data_O.
- repeat_O  output  1  one-cycle strobe for a valid repeat frame.
- err_O  output  1  one-cycle strobe on any protocol violation.
- busy_O  output  1  high in every state except IDLE.

## Operation
- IRDA_RXD passes through a 2-FF synchronizer, then a 1-FF delay. fall = delayed & ~sync; rise = ~delayed & sync.
- Width timer:
  - Prescaler counts 0..TICK_DIV-1. On wrap it increments an 8-bit width count, which saturates at 255 (12.75 ms).
  - Any edge clears the prescaler and the width count in the same cycle. The edge wins over a simultaneous tick.
  - Classification uses the width count value present in the edge cycle.
- States: IDLE, LEAD_LOW, LEAD_HIGH, BIT_LOW, BIT_HIGH, REP_STOP.
- IDLE:
  - fall -> LEAD_LOW.
  - rise is ignored. This covers the stop burst's rising edge and glitches.
- LEAD_LOW, on rise:
  - width 160..200 -> LEAD_HIGH.
  - Otherwise err -> IDLE.
- LEAD_HIGH, on fall:
  - 80..100 -> BIT_LOW, bit index cleared to 0.
  - 36..54 -> REP_STOP.
  - Otherwise err -> IDLE.
- BIT_LOW, on rise:
  - 7..15 -> BIT_HIGH.
  - Otherwise err -> IDLE.
- BIT_HIGH, on fall:
  - 7..15 shifts in 0; 28..40 shifts in 1. Shift is right, new bit enters bit 31.
  - Any other width: err -> IDLE.
  - After the 32nd bit, run the complement check, then go to IDLE.
  - Check pass: latch data_O, pulse data_valid_O, set have_frame.
  - Check fail: err, data_O unchanged.
  - Otherwise index+1 -> BIT_LOW.
- REP_STOP, on rise:
  - Width 7..15 and have_frame=1 -> repeat_O, IDLE.
  - Width 7..15 and have_frame=0 -> err, IDLE.
  - Any other width -> err, IDLE.
- Timeout: width count reaching 255 in any non-IDLE state -> err -> IDLE.
- Window bounds are inclusive on both ends.
- At most one of data_valid_O, repeat_O, err_O is high in any cycle.

## Timing
- Reset values:
  - State IDLE.
  - All counters, shift register, have_frame, data_O = 0.
  - All strobes 0, busy_O 0.
  - Synchronizer and delay flops = 1 (idle line).
- rst mid-frame: next cycle is IDLE with no strobe emitted. have_frame and data_O are cleared.
- Pin-to-edge latency: 3 CLOCK_50 cycles. Pin-to-strobe latency: 4 cycles. The strobe is registered in the cycle after the edge.
- Decode rises within 1 tick of error after a 50 us measurement granularity. Windows absorb ±~15 % carrier-receiver distortion.
- data_O changes only in the cycle data_valid_O is high.

## Structure
- Package ir_nec_pkg holds:
  - State encoding.
  - Window constants (LEAD_LOW 160/200, LEAD_HIGH 80/100, REP_HIGH 36/54, SHORT 7/15, LONG 28/40, TIMEOUT 255).
  - Frame width 32.
- Sub-module ir_width_timer: synchronizer, edge detect, prescaler, saturating width count. Outputs: fall, rise, width[7:0], timeout.
- Top: FSM, bit index [5:0], shift register, complement check, output registers.

## Test plan
- Nominal frame:
  - Stimulus: 9 ms low, 4.5 ms high, address 0x00/0xFF, command 0x45/0xBA, 562 us stop.
  - Response: data_valid_O one pulse, data_O = 0xBA45FF00, err_O never high.
- Repeat frame:
  - Stimulus: 9 ms low, 2.25 ms high, 562 us low, sent after the nominal frame.
  - Response: repeat_O one pulse, data_O unchanged. Same repeat after reset -> err_O pulse, no repeat_O.
- Complement failure:
  - Stimulus: command 0x45 sent with byte3 = 0xBB.
  - Response: err_O pulse, data_valid_O 0, data_O keeps its previous value.
  - Variant: CHECK_ADDR=0 with address 0x12/0x34 -> data_valid_O pulse.
- Window edges:
  - Stimulus: leader low of 159 ticks, then 160 ticks.
  - Response: 159 -> err_O on rise. 160 -> proceeds to LEAD_HIGH.
  - Bit high of 16 ticks -> err_O; bit high of 28 ticks -> bit 1 shifted in.
- Timeout and reset:
  - Stimulus: line held high 13 ms after bit 10.
  - Response: err_O when width hits 255, then busy_O 0.
  - rst pulse during bit 20 -> next cycle state IDLE, all outputs 0, no strobe. A following full frame decodes normally.
- Glitch in IDLE:
  - Stimulus: 100 us low pulse on an idle line.
  - Response: enters LEAD_LOW, err_O on rise, returns to IDLE. A leader starting 1 ms later decodes correctly.
